// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_serializer serial transmitter.
// The PARITY state is only entered when PISO_PARITY_EN is defined.
package piso_pkg;

   localparam int unsigned PISO_DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } piso_state_t;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of piso_serializer.
// The slave modport is the transmitter; the master modport is the producer/observer.
interface piso_serializer_if
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) ();

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             done;

   modport master (
      output load_valid, load_data,
      input  load_ready, ser_out, ser_valid, busy, done
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, ser_out, ser_valid, busy, done
   );

endinterface

// File: rtl/piso_shreg.sv
// WIDTH-bit loadable right-shift register; zeros enter at the MSB.
// Load has priority over shift so a back-to-back word replaces the draining one.
module piso_shreg
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] d,
   output logic             sout
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift_en) begin
         q <= {1'b0, q[WIDTH-1:1]};
      end
   end

   assign sout = q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, LSB first, valid/ready load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = PISO_DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   piso_serializer_if.slave    bus
);

   localparam int unsigned    CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   piso_state_t   state;
   logic [CW-1:0] cnt;
   logic          shreg_lsb;
   logic          accept;
   logic          last_bit;
   logic          shift_en;

`ifdef PISO_PARITY_EN
   logic          par;

   assign last_bit    = (state == PARITY);
   assign bus.ser_out = ((state == SHIFT) && shreg_lsb) || ((state == PARITY) && par);
`else
   assign last_bit    = (state == SHIFT) && (cnt == LAST_BIT);
   assign bus.ser_out = (state == SHIFT) && shreg_lsb;
`endif

   assign bus.load_ready = rst_n && ((state == IDLE) || last_bit);
   assign accept         = bus.load_valid && bus.load_ready;
   assign shift_en       = (state == SHIFT);
   assign bus.ser_valid  = (state != IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = last_bit;

   // An accept can only occur in IDLE or on the final frame bit, so it
   // takes priority and covers both the idle start and the back-to-back restart.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else if (accept) begin
         state <= SHIFT;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= ^bus.load_data;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt == LAST_BIT) begin
`ifdef PISO_PARITY_EN
                  state <= PARITY;
`else
                  state <= IDLE;
`endif
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   piso_shreg #(.WIDTH(WIDTH)) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .shift_en (shift_en),
      .d        (bus.load_data),
      .sout     (shreg_lsb)
   );

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: accepted words become timestamped expected
// bits in a queue; a negedge monitor compares the serial stream and a SIPO loopback.
module tb_piso_serializer;
   import piso_pkg::*;

   localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   piso_serializer_if #(.WIDTH(W)) bus ();

   piso_serializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          b;
      logic          last;
      logic          last_data;
      logic [W-1:0]  word;
      int unsigned   cyc;
   } exp_t;

   exp_t        sbq[$];
   int unsigned edge_cnt   = 0;
   int unsigned accepts    = 0;
   int unsigned sent       = 0;
   int          errors     = 0;
   int          checks     = 0;
   logic [W-1:0] rx_q      = '0;
   logic [W-1:0] rx_exp    = '0;
   bit          rx_pending = 1'b0;

   // Receiver end of the link: bits enter at the MSB so bit 0 lands at index 0.
   always @(posedge clk) rx_q <= {bus.ser_out, rx_q[W-1:1]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, edge_cnt);
      end
   endtask

   // A frame is the word's bits LSB first, optionally followed by its even parity.
   function automatic void push_frame(input logic [W-1:0] w, input int unsigned first_cyc);
      exp_t        e;
      int unsigned ones = 0;
      for (int unsigned k = 0; k < W; k++) begin
         e.b         = w[k];
         e.last      = (k == W - 1) && !PAR;
         e.last_data = (k == W - 1);
         e.word      = w;
         e.cyc       = first_cyc + k;
         sbq.push_back(e);
         if (w[k]) ones++;
      end
      if (PAR) begin
         e.b         = logic'(ones % 2);
         e.last      = 1'b1;
         e.last_data = 1'b0;
         e.word      = w;
         e.cyc       = first_cyc + W;
         sbq.push_back(e);
      end
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         sbq.delete();
         rx_pending = 1'b0;
      end else if (bus.load_valid && bus.load_ready) begin
         push_frame(bus.load_data, edge_cnt + 1);
         accepts++;
      end
      edge_cnt++;
   end

   always @(negedge clk) begin
      bit   exp_valid;
      exp_t e;
      if (rx_pending) begin
         check("rx_word", 32'(rx_q), 32'(rx_exp));
         rx_pending = 1'b0;
      end
      if (sbq.size() > 0 && sbq[0].cyc < edge_cnt) begin
         check("bit_timing", sbq[0].cyc, edge_cnt);
         void'(sbq.pop_front());
      end
      exp_valid = (sbq.size() > 0) && (sbq[0].cyc == edge_cnt);
      check("load_ready", 32'(bus.load_ready),
            32'(rst_n && (sbq.size() == 0 || (sbq.size() == 1 && exp_valid))));
      check("ser_valid", 32'(bus.ser_valid), 32'(exp_valid));
      check("busy", 32'(bus.busy), 32'(exp_valid));
      if (exp_valid) begin
         e = sbq.pop_front();
         check("ser_out", 32'(bus.ser_out), 32'(e.b));
         check("done", 32'(bus.done), 32'(e.last));
         if (e.last_data) begin
            rx_pending = 1'b1;
            rx_exp     = e.word;
         end
      end else begin
         check("ser_out_idle", 32'(bus.ser_out), 32'd0);
         check("done_idle", 32'(bus.done), 32'd0);
      end
   end

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w, input bit keep);
      int unsigned n   = 0;
      bit          hit = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = w;
      while (!hit && n < 100) begin
         @(posedge clk);
         hit = bus.load_ready && rst_n;
         n++;
         #1;
      end
      if (hit) begin
         sent++;
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: word %0h not accepted within %0d cycles", w, n);
      end
      if (!keep) begin
         bus.load_valid = 1'b0;
         bus.load_data  = W'($urandom);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      int unsigned  n;
      bit           keep;
      bus.load_valid = 1'b0;
      bus.load_data  = '0;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      send(4'b1011, 1'b0);
      idle(W + 3);
      send(4'b0110, 1'b0); idle(W + 2);
      send(4'b0000, 1'b0); idle(W + 2);
      send(4'b1111, 1'b0); idle(W + 2);
      send(4'b1001, 1'b0); idle(W + 2);

      send(4'b1100, 1'b1);
      send(4'b0011, 1'b0);
      idle(W + 3);

      send(4'b1010, 1'b0);
      idle(1);
      send(4'b0101, 1'b0);
      idle(W + 3);

      send(4'b1101, 1'b0);
      idle(2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      idle(1);
      send(4'b0111, 1'b0); idle(W + 2);
      send(4'b0011, 1'b0); idle(W + 2);

      for (int i = 0; i < 40; i++) begin
         w    = W'($urandom);
         keep = ($urandom_range(0, 2) == 0);
         send(w, keep);
         if (!keep) idle($urandom_range(0, W + 2));
      end
      bus.load_valid = 1'b0;

      n = 0;
      while (sbq.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected bits never transmitted", sbq.size());
      end
      idle(3);
      check("accept_count", accepts, sent);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clock, LSB first. It is the transmit end of the team's 1-bit serial link. Its `ser_out` drives the `d` input of the existing serial-in/parallel-out shift register directly. After WIDTH shifts, the receiver's parallel output holds the original word with bit 0 at index 0.

## Interface
Parameters:
- WIDTH, 4: data word width in bits; minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- load_valid  in  1  producer has a word on load_data.
- load_ready  out  1  block can accept a word this cycle.
- load_data  in  WIDTH  word to transmit.
- ser_out  out  1  serial data; feeds the receiver's `d`.
- ser_valid  out  1  ser_out carries a frame bit this cycle.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse during the last bit of a frame.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only when the Configuration macro is defined).
- Handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - load_ready = (state==IDLE) || (state is on the final frame bit).
  - load_ready is forced 0 while rst_n is low.
- On accept:
  - shift register ← load_data.
  - bit counter ← 0.
  - state → SHIFT.
- SHIFT:
  - ser_out = shreg[0].
  - Each edge: shreg ← {1'b0, shreg[WIDTH-1:1]}, cnt ← cnt+1.
  - When cnt == WIDTH-1: if PARITY is enabled, go to PARITY; otherwise go to IDLE, or restart SHIFT if a new word is accepted on that same edge.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1 and never wraps mid-frame.
- load_valid while load_ready is low is ignored; load_data is not sampled.
- The word is captured at accept, so load_data may change freely afterwards.
- Reset (including mid-frame): state → IDLE, shreg and cnt cleared. The current frame is abandoned with no done pulse.

## Timing
- Reset values: ser_out 0, ser_valid 0, busy 0, done 0, load_ready 0 during reset. load_ready becomes 1 in the first cycle after rst_n goes high.
- Accept on edge N:
  - Bit 0 appears on ser_out in cycle N+1 (after edge N).
  - Bit k appears in cycle N+1+k.
- ser_valid and busy are high for exactly WIDTH cycles per frame (WIDTH+1 with parity).
- done is high in the cycle carrying the final frame bit.
- Back-to-back: a word accepted on the edge that ends the final bit starts its bit 0 in the very next cycle. ser_valid has no gap and done pulses once per frame.
- ser_out is 0 whenever ser_valid is 0.
- Receiver alignment: the receiver's parallel output equals the word on the edge that ends the last data bit, i.e. WIDTH edges after the edge that launched bit 0.

## Configuration
- PISO_PARITY_EN defined:
  - After the data bits, one extra cycle in PARITY drives ser_out = ^word (even parity over the captured word).
  - ser_valid stays high during that cycle; done and the back-to-back accept move to the parity cycle.
  - Frame length is WIDTH+1.
- Undefined: the PARITY state and parity register are absent, and the frame is WIDTH bits.

## Structure
- Shared package piso_pkg holds:
  - the state enum type piso_state_t (IDLE, SHIFT, PARITY);
  - localparam PISO_DEFAULT_WIDTH = 4.
- One sub-module, piso_shreg: a WIDTH-bit loadable right-shift register with synchronous active-low reset, load, and shift enable. The FSM, counter, handshake and parity logic stay in the top module.

## Test plan
- After reset: load_ready=1, ser_valid=0. Load 4'b1011 → ser_out 1,1,0,1 on consecutive cycles; done on the 4th; ser_valid for exactly 4 cycles.
- Loopback: ser_out into the SIPO receiver; load 4'b0110 → receiver q == 4'b0110 at the edge ending bit 3. Repeat for 4'b0000, 4'b1111 and 4'b1001.
- Back-to-back: load_valid held with 4'b1100 then 4'b0011 → serial stream 0,0,1,1,1,1,0,0 with no ser_valid gap; two done pulses.
- Busy ignore: load 4'b1010; assert load_valid with 4'b0101 in cycle 2 → transmitted bits stay 0,1,0,1; second word accepted only when load_ready=1.
- Reset mid-frame: rst_n low after bit 1 for one edge → all outputs 0 next cycle, no done pulse; load_ready=1 one cycle after release; a new word transmits correctly.
- With PISO_PARITY_EN: load 4'b0111 → ser_out 1,1,1,0 then parity 1; done on the 5th cycle. Load 4'b0011 → parity bit 0.
